// File: rtl/ex_stage.sv
// ex_stage: execute stage of the integer pipeline.
//   ID/EX register -> logic/shift ALU -> EX/MEM register, with the EX-stage
//   write (wreg/wd/wdata) returned combinationally for ID-stage bypass.
// Optional build macro SERIAL_SHIFT_EN: replaces the barrel shifter with a
//   serial shifter (SHIFT_STEP bits per cycle) that holds the stage busy via
//   stallreq_o. Without it every op is single-cycle and stallreq_o is 0.
module ex_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
`ifdef SERIAL_SHIFT_EN
   ,
   parameter int SHIFT_STEP = 4
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid_i,
   input  logic [7:0]        id_aluop_i,
   input  logic [2:0]        id_alusel_i,
   input  logic [DATA_W-1:0] id_reg1_i,
   input  logic [DATA_W-1:0] id_reg2_i,
   input  logic [ADDR_W-1:0] id_wd_i,
   input  logic              id_wreg_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              stallreq_o,
   output logic              ex_wreg_o,
   output logic [ADDR_W-1:0] ex_wd_o,
   output logic [DATA_W-1:0] ex_wdata_o,
   output logic              mem_wreg_o,
   output logic [ADDR_W-1:0] mem_wd_o,
   output logic [DATA_W-1:0] mem_wdata_o
);

   localparam logic [7:0] OP_AND = 8'b0010_0100;
   localparam logic [7:0] OP_OR  = 8'b0010_0101;
   localparam logic [7:0] OP_XOR = 8'b0010_0110;
   localparam logic [7:0] OP_NOR = 8'b0010_0111;
   localparam logic [7:0] OP_SLL = 8'b0111_1100;
   localparam logic [7:0] OP_SRL = 8'b0000_0010;
   localparam logic [7:0] OP_SRA = 8'b0000_0011;

   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;

   // ID/EX register
   logic              valid_q, valid_d;
   logic [7:0]        aluop_q, aluop_d;
   logic [2:0]        alusel_q, alusel_d;
   logic [DATA_W-1:0] reg1_q, reg1_d;
   logic [DATA_W-1:0] reg2_q, reg2_d;
   logic [ADDR_W-1:0] wd_q, wd_d;
   logic              wreg_q, wreg_d;

   // EX/MEM register
   logic              mem_wreg_q, mem_wreg_d;
   logic [ADDR_W-1:0] mem_wd_q, mem_wd_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              stallreq;
   logic              adv;
   logic              is_logic_op;
   logic              is_shift_op;
   logic              shift_valid;
   logic [4:0]        shamt;
   logic [DATA_W-1:0] logic_res;
   logic [DATA_W-1:0] shift_res;
   logic [DATA_W-1:0] result;

   function automatic logic [DATA_W-1:0] shift_by(input logic [7:0]        op,
                                                  input logic [DATA_W-1:0] val,
                                                  input logic [4:0]        amt);
      case (op)
         OP_SLL:  return val << amt;
         OP_SRL:  return val >> amt;
         default: return DATA_W'($signed(val) >>> amt);
      endcase
   endfunction

   assign shamt       = reg1_q[4:0];
   assign shift_valid = valid_q && (alusel_q == SEL_SHIFT) && is_shift_op;
   assign adv         = !stall_i && !stallreq;

   // Decode the held aluop into op class and compute the logic result.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      is_logic_op = 1'b0;
      is_shift_op = 1'b0;
      logic_res   = '0;
      case (aluop_q)
         OP_AND: begin is_logic_op = 1'b1; logic_res = reg1_q & reg2_q;    end
         OP_OR:  begin is_logic_op = 1'b1; logic_res = reg1_q | reg2_q;    end
         OP_XOR: begin is_logic_op = 1'b1; logic_res = reg1_q ^ reg2_q;    end
         OP_NOR: begin is_logic_op = 1'b1; logic_res = ~(reg1_q | reg2_q); end
         OP_SLL, OP_SRL, OP_SRA: is_shift_op = 1'b1;
         default: ;
      endcase
   end

`ifdef SERIAL_SHIFT_EN
   typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

   localparam logic [4:0] STEP = 5'(SHIFT_STEP);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] work_q, work_d;
   logic [4:0]        rem_q, rem_d;
   logic [4:0]        step_amt;
   logic [DATA_W-1:0] stepped;

   assign step_amt = (rem_q > STEP) ? STEP : rem_q;
   assign stepped  = shift_by(aluop_q, work_q, step_amt);

   // Serial shifter FSM: load on a valid non-zero shift, step while not stalled,
   // and present the final step combinationally so the last cycle can commit.
   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      rem_d     = rem_q;
      stallreq  = 1'b0;
      shift_res = reg2_q;
      case (state_q)
         ST_IDLE: begin
            if (shift_valid && shamt != 5'd0) begin
               stallreq = 1'b1;
               if (!stall_i) begin
                  state_d = ST_SHIFT;
                  work_d  = reg2_q;
                  rem_d   = shamt;
               end
            end
         end
         ST_SHIFT: begin
            shift_res = stepped;
            if (rem_q > STEP) begin
               stallreq = 1'b1;
               if (!stall_i) begin
                  work_d = stepped;
                  rem_d  = rem_q - step_amt;
               end
            end else if (!stall_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush_i) state_d = ST_IDLE;
   end

   // Serial shifter state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         work_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
      end
   end
`else
   assign shift_res = shift_by(aluop_q, reg2_q, shamt);
   assign stallreq  = 1'b0;
`endif

   // Result select: a mismatched aluop/alusel pair yields zero.
   always_comb begin
      result = '0;
      if (alusel_q == SEL_LOGIC && is_logic_op)      result = logic_res;
      else if (alusel_q == SEL_SHIFT && is_shift_op) result = shift_res;
   end

   assign stallreq_o = stallreq;
   assign ex_wreg_o  = valid_q & wreg_q;
   assign ex_wd_o    = valid_q ? wd_q   : '0;
   assign ex_wdata_o = valid_q ? result : '0;

   // Next state of both pipeline registers: flush wins, then advance, else hold.
   always_comb begin
      valid_d     = valid_q;
      aluop_d     = aluop_q;
      alusel_d    = alusel_q;
      reg1_d      = reg1_q;
      reg2_d      = reg2_q;
      wd_d        = wd_q;
      wreg_d      = wreg_q;
      mem_wreg_d  = mem_wreg_q;
      mem_wd_d    = mem_wd_q;
      mem_wdata_d = mem_wdata_q;
      if (flush_i) begin
         valid_d    = 1'b0;
         mem_wreg_d = 1'b0;
      end else if (adv) begin
         valid_d     = id_valid_i;
         aluop_d     = id_aluop_i;
         alusel_d    = id_alusel_i;
         reg1_d      = id_reg1_i;
         reg2_d      = id_reg2_i;
         wd_d        = id_wd_i;
         wreg_d      = id_wreg_i;
         mem_wreg_d  = ex_wreg_o;
         mem_wd_d    = ex_wd_o;
         mem_wdata_d = ex_wdata_o;
      end
   end

   // Pipeline registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state elements use non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         valid_q     <= 1'b0;
         aluop_q     <= '0;
         alusel_q    <= '0;
         reg1_q      <= '0;
         reg2_q      <= '0;
         wd_q        <= '0;
         wreg_q      <= 1'b0;
         mem_wreg_q  <= 1'b0;
         mem_wd_q    <= '0;
         mem_wdata_q <= '0;
      end else begin
         valid_q     <= valid_d;
         aluop_q     <= aluop_d;
         alusel_q    <= alusel_d;
         reg1_q      <= reg1_d;
         reg2_q      <= reg2_d;
         wd_q        <= wd_d;
         wreg_q      <= wreg_d;
         mem_wreg_q  <= mem_wreg_d;
         mem_wd_q    <= mem_wd_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_wreg_o  = mem_wreg_q;
   assign mem_wd_o    = mem_wd_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized stimulus
// against a cycle-level behavioural model. Build with +define+SERIAL_SHIFT_EN
// to exercise the serial shifter.
module tb_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
   } bundle_t;

   localparam logic [7:0] AND_OP = 8'b0010_0100;
   localparam logic [7:0] OR_OP  = 8'b0010_0101;
   localparam logic [7:0] XOR_OP = 8'b0010_0110;
   localparam logic [7:0] NOR_OP = 8'b0010_0111;
   localparam logic [7:0] SLL_OP = 8'b0111_1100;
   localparam logic [7:0] SRL_OP = 8'b0000_0010;
   localparam logic [7:0] SRA_OP = 8'b0000_0011;
   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
`ifdef SERIAL_SHIFT_EN
   localparam bit SERIAL = 1'b1;
`else
   localparam bit SERIAL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid_i = 1'b0;
   logic [7:0]  id_aluop_i = '0;
   logic [2:0]  id_alusel_i = '0;
   logic [31:0] id_reg1_i = '0;
   logic [31:0] id_reg2_i = '0;
   logic [4:0]  id_wd_i = '0;
   logic        id_wreg_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        stallreq_o;
   logic        ex_wreg_o;
   logic [4:0]  ex_wd_o;
   logic [31:0] ex_wdata_o;
   logic        mem_wreg_o;
   logic [4:0]  mem_wd_o;
   logic [31:0] mem_wdata_o;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid_i  (id_valid_i),
      .id_aluop_i  (id_aluop_i),
      .id_alusel_i (id_alusel_i),
      .id_reg1_i   (id_reg1_i),
      .id_reg2_i   (id_reg2_i),
      .id_wd_i     (id_wd_i),
      .id_wreg_i   (id_wreg_i),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .stallreq_o  (stallreq_o),
      .ex_wreg_o   (ex_wreg_o),
      .ex_wd_o     (ex_wd_o),
      .ex_wdata_o  (ex_wdata_o),
      .mem_wreg_o  (mem_wreg_o),
      .mem_wd_o    (mem_wd_o),
      .mem_wdata_o (mem_wdata_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Behavioural model state
   bundle_t     m_ex;
   int          m_busy;
   logic        m_mem_wreg;
   logic [4:0]  m_mem_wd;
   logic [31:0] m_mem_wdata;

   // Architectural result of a bundle, from arithmetic on powers of two.
   function automatic logic [31:0] ref_result(input bundle_t b);
      logic [63:0] pow;
      logic [63:0] two32;
      logic [31:0] q;
      two32 = 64'h1_0000_0000;
      pow   = 64'd1 << b.reg1[4:0];
      if (!b.valid) return 32'h0;
      if (b.alusel == SEL_LOGIC) begin
         case (b.aluop)
            AND_OP:  return b.reg1 & b.reg2;
            OR_OP:   return b.reg1 | b.reg2;
            XOR_OP:  return b.reg1 ^ b.reg2;
            NOR_OP:  return ~(b.reg1 | b.reg2);
            default: return 32'h0;
         endcase
      end else if (b.alusel == SEL_SHIFT) begin
         case (b.aluop)
            SLL_OP:  return 32'(64'(b.reg2) * pow);
            SRL_OP:  return 32'(64'(b.reg2) / pow);
            SRA_OP: begin
               q = 32'(64'(b.reg2) / pow);
               if (b.reg2[31]) q = q | 32'(two32 - two32 / pow);
               return q;
            end
            default: return 32'h0;
         endcase
      end
      return 32'h0;
   endfunction

   // Number of stalled cycles a bundle costs once it sits in EX.
   function automatic int busy_for(input bundle_t b);
      int amt;
      amt = int'(b.reg1[4:0]);
      if (SERIAL && b.valid && b.alusel == SEL_SHIFT &&
          (b.aluop inside {SLL_OP, SRL_OP, SRA_OP}) && amt != 0)
         return (amt + 3) / 4;
      return 0;
   endfunction

   function automatic bundle_t mk(input logic v, input logic [7:0] op, input logic [2:0] sel,
                                  input logic [31:0] r1, input logic [31:0] r2,
                                  input logic [4:0] wd, input logic we);
      bundle_t b;
      b.valid = v; b.aluop = op; b.alusel = sel; b.reg1 = r1; b.reg2 = r2; b.wd = wd; b.wreg = we;
      return b;
   endfunction

   task automatic check_outputs();
      check("stallreq", 32'(stallreq_o), 32'(m_busy > 0));
      check("ex_wreg", 32'(ex_wreg_o), 32'(m_ex.valid && m_ex.wreg));
      check("ex_wd", 32'(ex_wd_o), m_ex.valid ? 32'(m_ex.wd) : 32'h0);
      if (m_busy == 0) check("ex_wdata", ex_wdata_o, ref_result(m_ex));
      check("mem_wreg", 32'(mem_wreg_o), 32'(m_mem_wreg));
      if (m_mem_wreg) begin
         check("mem_wd", 32'(mem_wd_o), 32'(m_mem_wd));
         check("mem_wdata", mem_wdata_o, m_mem_wdata);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, check at negedge.
   task automatic cycle(input bundle_t b, input bit stl, input bit fl, input bit rs);
      bit adv;
      id_valid_i = b.valid; id_aluop_i = b.aluop; id_alusel_i = b.alusel;
      id_reg1_i = b.reg1; id_reg2_i = b.reg2; id_wd_i = b.wd; id_wreg_i = b.wreg;
      stall_i = stl; flush_i = fl; rst = rs;
      @(posedge clk);
      adv = !stl && (m_busy == 0);
      if (rs) begin
         m_ex = '0; m_busy = 0; m_mem_wreg = 1'b0; m_mem_wd = '0; m_mem_wdata = '0;
      end else if (fl) begin
         m_ex.valid = 1'b0; m_mem_wreg = 1'b0; m_busy = 0;
      end else if (adv) begin
         m_mem_wreg  = m_ex.valid && m_ex.wreg;
         m_mem_wd    = m_ex.wd;
         m_mem_wdata = ref_result(m_ex);
         m_ex        = b;
         m_busy      = busy_for(b);
      end else if (!stl && m_busy > 0) begin
         m_busy--;
      end
      @(negedge clk);
      check_outputs();
   endtask

   // Present a bundle and idle until the model says its result is final.
   task automatic issue(input bundle_t b);
      cycle(b, 1'b0, 1'b0, 1'b0);
      while (m_busy > 0) cycle('0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bundle_t b;
      logic [7:0] ops [8];
      int cnt;
      ops = '{AND_OP, OR_OP, XOR_OP, NOR_OP, SLL_OP, SRL_OP, SRA_OP, 8'h00};
      m_ex = '0; m_busy = 0; m_mem_wreg = 1'b0; m_mem_wd = '0; m_mem_wdata = '0;
      @(negedge clk);

      // Reset then idle
      cycle('0, 1'b0, 1'b0, 1'b1);
      cycle('0, 1'b0, 1'b0, 1'b1);
      check("rst_mem_wreg", 32'(mem_wreg_o), 32'h0);
      check("rst_mem_wdata", mem_wdata_o, 32'h0);
      check("rst_ex_wreg", 32'(ex_wreg_o), 32'h0);
      check("rst_stallreq", 32'(stallreq_o), 32'h0);
      cycle('0, 1'b0, 1'b0, 1'b0);

      // Logic ops
      issue(mk(1'b1, OR_OP, SEL_LOGIC, 32'h0000FF00, 32'h000000FF, 5'd3, 1'b1));
      check("or_ex_wdata", ex_wdata_o, 32'h0000FFFF);
      check("or_ex_wd", 32'(ex_wd_o), 32'd3);
      issue(mk(1'b1, NOR_OP, SEL_LOGIC, 32'h0, 32'h0, 5'd4, 1'b1));
      check("or_mem_wdata", mem_wdata_o, 32'h0000FFFF);
      check("or_mem_wd", 32'(mem_wd_o), 32'd3);
      check("nor_ex_wdata", ex_wdata_o, 32'hFFFFFFFF);
      cycle('0, 1'b0, 1'b0, 1'b0);
      check("nor_mem_wdata", mem_wdata_o, 32'hFFFFFFFF);

      // Shifts
      issue(mk(1'b1, SRA_OP, SEL_SHIFT, 32'd4, 32'h80000000, 5'd5, 1'b1));
      check("sra_ex_wdata", ex_wdata_o, 32'hF8000000);
      issue(mk(1'b1, SRL_OP, SEL_SHIFT, 32'd4, 32'h80000000, 5'd6, 1'b1));
      check("sra_mem_wdata", mem_wdata_o, 32'hF8000000);
      check("srl_ex_wdata", ex_wdata_o, 32'h08000000);
      issue(mk(1'b1, SLL_OP, SEL_SHIFT, 32'd31, 32'h00000001, 5'd7, 1'b1));
      check("sll31_ex_wdata", ex_wdata_o, 32'h80000000);
      issue(mk(1'b1, SRA_OP, SEL_SHIFT, 32'hFFFFFFE0, 32'h80000001, 5'd8, 1'b1));
      check("amt0_stallreq", 32'(stallreq_o), 32'h0);
      check("amt0_ex_wdata", ex_wdata_o, 32'h80000001);

      // Downstream stall with XOR in EX, then release
      issue(mk(1'b1, XOR_OP, SEL_LOGIC, 32'hA5A5A5A5, 32'h0F0F0F0F, 5'd9, 1'b1));
      for (int i = 0; i < 3; i++) begin
         cycle(mk(1'b1, AND_OP, SEL_LOGIC, 32'hFFFFFFFF, 32'h1234, 5'd1, 1'b1), 1'b1, 1'b0, 1'b0);
         check("stall_ex_hold", ex_wdata_o, 32'hAAAAAAAA);
         check("stall_mem_hold", mem_wdata_o, 32'h80000001);
      end
      cycle('0, 1'b0, 1'b0, 1'b0);
      check("stall_release_mem", mem_wdata_o, 32'hAAAAAAAA);

      // Flush together with stall
      issue(mk(1'b1, OR_OP, SEL_LOGIC, 32'h1, 32'h2, 5'd10, 1'b1));
      cycle('0, 1'b1, 1'b1, 1'b0);
      check("flush_mem_wreg", 32'(mem_wreg_o), 32'h0);
      check("flush_ex_wreg", 32'(ex_wreg_o), 32'h0);

      // Mismatched encoding and invalid bundle
      issue(mk(1'b1, AND_OP, SEL_SHIFT, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 1'b1));
      cycle('0, 1'b0, 1'b0, 1'b0);
      check("mismatch_mem_wdata", mem_wdata_o, 32'h0);
      check("mismatch_mem_wreg", 32'(mem_wreg_o), 32'h1);
      issue(mk(1'b0, OR_OP, SEL_LOGIC, 32'h5, 32'h6, 5'd12, 1'b1));
      cycle('0, 1'b0, 1'b0, 1'b0);
      check("invalid_mem_wreg", 32'(mem_wreg_o), 32'h0);

      if (SERIAL) begin
         // SLL by 10: three busy cycles, then commit
         cycle(mk(1'b1, SLL_OP, SEL_SHIFT, 32'd10, 32'h1, 5'd13, 1'b1), 1'b0, 1'b0, 1'b0);
         cnt = 0;
         for (int i = 0; i < 8 && stallreq_o === 1'b1; i++) begin
            cnt++;
            cycle('0, 1'b0, 1'b0, 1'b0);
         end
         check("sll10_busy_cycles", 32'(cnt), 32'd3);
         check("sll10_ex_wdata", ex_wdata_o, 32'h00000400);
         cycle('0, 1'b0, 1'b0, 1'b0);
         check("sll10_mem_wdata", mem_wdata_o, 32'h00000400);
         check("sll10_mem_wreg", 32'(mem_wreg_o), 32'h1);
         // Flush in the second busy cycle
         cycle(mk(1'b1, SLL_OP, SEL_SHIFT, 32'd10, 32'h1, 5'd14, 1'b1), 1'b0, 1'b0, 1'b0);
         cycle('0, 1'b0, 1'b0, 1'b0);
         cycle('0, 1'b0, 1'b1, 1'b0);
         check("sflush_stallreq", 32'(stallreq_o), 32'h0);
         check("sflush_mem_wreg", 32'(mem_wreg_o), 32'h0);
         cycle('0, 1'b0, 1'b0, 1'b0);
         check("sflush_no_commit", 32'(mem_wreg_o), 32'h0);
      end

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         int r;
         r = $urandom_range(0, 9);
         b.aluop  = (r < 8) ? ops[r] : 8'($urandom);
         if ($urandom_range(0, 4) == 0) b.alusel = 3'($urandom);
         else b.alusel = (b.aluop inside {SLL_OP, SRL_OP, SRA_OP}) ? SEL_SHIFT : SEL_LOGIC;
         b.valid = ($urandom_range(0, 9) != 0);
         b.reg1  = $urandom;
         b.reg2  = $urandom;
         b.wd    = 5'($urandom);
         b.wreg  = ($urandom_range(0, 7) != 0);
         cycle(b, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 99) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that consumes the ID stage's decode bundle: aluop, alusel, operand 1, operand 2, destination register and write enable.
- Contains the ID/EX pipeline register, the logic/shift ALU and the EX/MEM pipeline register.
- Returns the current EX-stage write (ex_wreg/ex_wd/ex_wdata) combinationally to the ID stage for bypass.
- Raises stallreq_o while a multi-cycle operation occupies the stage.

Parameters:
- DATA_W, 32, operand/result width.
- ADDR_W, 5, register address width.
- SHIFT_STEP, 4, bits shifted per cycle by the serial shifter; only used with SERIAL_SHIFT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- id_valid_i  in  1  decode bundle valid.
- id_aluop_i  in  8  ALU op: NOP 00000000, AND 00100100, OR 00100101, XOR 00100110, NOR 00100111, SLL 01111100, SRL 00000010, SRA 00000011.
- id_alusel_i  in  3  result select: NOP 000, LOGIC 001, SHIFT 010.
- id_reg1_i  in  DATA_W  operand 1; the shift amount is bits [4:0].
- id_reg2_i  in  DATA_W  operand 2; the shifted value for shifts.
- id_wd_i  in  ADDR_W  destination register.
- id_wreg_i  in  1  write enable.
- stall_i  in  1  downstream hold.
- flush_i  in  1  discard the stage contents.
- stallreq_o  out  1  stage busy; upstream must hold its bundle.
- ex_wreg_o  out  1  bypass: EX write enable (combinational).
- ex_wd_o  out  ADDR_W  bypass: EX destination (combinational).
- ex_wdata_o  out  DATA_W  bypass: EX result (combinational).
- mem_wreg_o  out  1  EX/MEM write enable (registered).
- mem_wd_o  out  ADDR_W  EX/MEM destination (registered).
- mem_wdata_o  out  DATA_W  EX/MEM result (registered).

Behaviour:
- Reset:
  - All ID/EX and EX/MEM fields, the valid bits and the FSM state clear to 0.
  - stallreq_o=0, ex_*=0, mem_*=0 in the cycle after the reset edge.
  - Reset mid-operation abandons any shift in progress.
- Advance condition: adv = !stall_i && !stallreq_o.
- ID/EX register:
  - On adv, loads the id_* bundle; the valid bit is set to id_valid_i.
  - When adv is 0, it holds.
- EX/MEM register:
  - On adv, loads {wreg = valid && wreg, wd, result}.
  - When adv is 0, it holds.
- Latency:
  - A bundle presented before edge N is in EX during cycle N→N+1.
  - It appears on mem_* after edge N+1.
- Flush:
  - On an edge with flush_i=1, the ID/EX valid clears, EX/MEM wreg clears and the FSM returns to IDLE.
  - Flush has priority over stall_i and over reset-free advance.
- Logic ops: AND/OR/XOR operate bitwise on reg1, reg2; NOR = ~(reg1|reg2).
- Shift ops:
  - SLL = reg2 << reg1[4:0].
  - SRL = logical right shift.
  - SRA = arithmetic right shift (sign = reg2[31]).
  - The shift amount is 0..31; amount 0 returns reg2.
- Result select:
  - alusel LOGIC selects the logic result; SHIFT selects the shift result.
  - Any other alusel, or an aluop that does not match alusel, gives result 0, while wreg is passed through unchanged.
- Bypass outputs:
  - ex_wreg_o = valid && wreg; ex_wd_o = wd; ex_wdata_o = result.
  - All are zero when valid=0.
- Stall from downstream: stall_i=1 freezes both registers and the FSM.
- Without SERIAL_SHIFT_EN, stallreq_o is tied 0 and every op is single-cycle.

Optional Feature:
- Macro: SERIAL_SHIFT_EN.
- When defined, the barrel shifter is replaced by a serial shifter with FSM states IDLE and SHIFT, a working register and a 5-bit remaining counter.
- IDLE→SHIFT:
  - Taken when the ID/EX register holds a valid SHIFT op with amount>0.
  - On entry, the working register = reg2 and remaining = amount.
  - stallreq_o=1 from the first EX cycle of the shift.
- SHIFT state:
  - Each non-stalled cycle shifts by min(SHIFT_STEP, remaining) and decrements remaining by the same.
  - When remaining reaches 0, stallreq_o drops and the next adv commits the working register to EX/MEM; the FSM returns to IDLE.
  - A shift of amount k occupies ceil(k/SHIFT_STEP)+1 EX cycles.
  - Amount 0 takes 1 cycle and does not raise stallreq_o.
- Bypass during a shift: ex_wreg_o stays asserted; ex_wdata_o is final only when stallreq_o=0. The ID stage discards bypass data while it is stalled.
- stall_i during SHIFT freezes the counter.
- flush_i during SHIFT aborts the shift, returns to IDLE and drops stallreq_o on the next cycle.

Test Plan:
- Reset then idle: after the rst edge, mem_wreg_o=0, mem_wdata_o=0, ex_wreg_o=0, stallreq_o=0.
- Logic op: OR with reg1=0x0000FF00, reg2=0x000000FF, wd=3, wreg=1 → ex_wdata_o=0x0000FFFF with ex_wd_o=3 one cycle after capture; the same values appear on mem_* one edge later. Repeat for NOR with 0,0 → 0xFFFFFFFF.
- Shifts:
  - SRA reg2=0x80000000, reg1=4 → 0xF8000000.
  - SRL of the same values → 0x08000000.
  - SLL reg2=1, reg1=31 → 0x80000000.
  - Amount 0 → reg2 unchanged.
- stall_i=1 held for 3 cycles with XOR in EX → ID/EX and mem_* are unchanged for those 3 cycles and resume on release. flush_i together with stall_i → mem_wreg_o=0 and ex_wreg_o=0 next cycle.
- Mismatched encoding: alusel=SHIFT with aluop=AND, wreg=1 → mem_wdata_o=0, mem_wreg_o=1. Invalid bundle (id_valid_i=0, wreg=1) → mem_wreg_o=0.
- With SERIAL_SHIFT_EN:
  - SLL amount 10 → stallreq_o high for 3 cycles; result 1<<10=0x400 on mem_wdata_o after release.
  - flush_i in the 2nd busy cycle → stallreq_o low next cycle and no write committed.
